// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder: decoded fields in, 32-bit instruction word out.
// Define ENC_RANGE_CHECK_EN to build the immediate range check that drives out_err.
module inst_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_err
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_ISH = 3'd2;
  localparam logic [2:0] FMT_S   = 3'd3;
  localparam logic [2:0] FMT_B   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_U   = 3'd6;
  localparam logic [2:0] FMT_RSV = 3'd7;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  function automatic logic [31:0] encode(input fields_t f);
    logic [31:0] w;
    w = '0;
    case (f.fmt)
      FMT_R:   w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      FMT_I:   w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_ISH: w = {f.funct7, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_S:   w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      FMT_B:   w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                    f.imm[4:1], f.imm[11], f.opcode};
      FMT_J:   w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
      FMT_U:   w = {f.imm[31:12], f.rd, f.opcode};
      default: w = '0;
    endcase
    return w;
  endfunction

`ifdef ENC_RANGE_CHECK_EN
  // A signed range fits when all bits above the field's sign bit equal the sign bit.
  function automatic logic range_err(input logic [2:0] f, input logic [31:0] v);
    logic e;
    e = 1'b0;
    case (f)
      FMT_I, FMT_S: e = !((&v[31:11]) || !(|v[31:11]));
      FMT_ISH:      e = |v[31:5];
      FMT_B:        e = !((&v[31:12]) || !(|v[31:12])) || v[0];
      FMT_J:        e = !((&v[31:20]) || !(|v[31:20])) || v[0];
      FMT_U:        e = |v[11:0];
      FMT_RSV:      e = 1'b1;
      default:      e = 1'b0;
    endcase
    return e;
  endfunction
`endif

  fields_t     fields_p1_q, fields_p1_d;
  logic        err_p1_q, err_p1_d;
  logic        vld_p1_q, vld_p1_d;
  logic        vld_p2_q, vld_p2_d;
  logic [31:0] word_p2_q, word_p2_d;
  logic        err_p2_q, err_p2_d;
  logic        s2_adv;
  logic        accept;
  logic        load_p2;
  fields_t     in_fields;

  always_comb begin
    in_fields = '{fmt: fmt, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                  funct3: funct3, funct7: funct7, imm: imm};
    s2_adv    = !vld_p2_q || out_ready;
    in_ready  = !vld_p1_q || s2_adv;
    accept    = in_valid && in_ready;
    load_p2   = vld_p1_q && s2_adv;

    // Stage 1: capture fields and precompute the error flag
    vld_p1_d    = accept || (vld_p1_q && !s2_adv);
    fields_p1_d = accept ? in_fields : fields_p1_q;
`ifdef ENC_RANGE_CHECK_EN
    err_p1_d    = accept ? range_err(fmt, imm) : err_p1_q;
`else
    err_p1_d    = accept ? (fmt == FMT_RSV) : err_p1_q;
`endif

    // Stage 2: assembled word, held while downstream stalls
    vld_p2_d  = s2_adv ? vld_p1_q : vld_p2_q;
    word_p2_d = load_p2 ? encode(fields_p1_q) : word_p2_q;
    err_p2_d  = load_p2 ? err_p1_q : err_p2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      word_p2_q <= '0;
      err_p2_q  <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      word_p2_q <= word_p2_d;
      err_p2_q  <= err_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    fields_p1_q <= fields_p1_d;
    err_p1_q    <= err_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign out_word  = word_p2_q;
  assign out_err   = err_p2_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector bench for inst_encoder: encoding table, latency, backpressure, async reset.
module tb_inst_encoder;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_err(out_err)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] word;
    logic        err;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    fmt = v.fmt; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc;
    int idx;
    int nout;
    int stale;
    bit rdy, oc, ic;
    logic [31:0] held;
    logic [31:0] rec[3];

    vecs[0]  = '{3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
    vecs[1]  = '{3'd3, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'h00000008, 32'h0021A423, 1'b0};
    vecs[2]  = '{3'd4, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
    vecs[3]  = '{3'd4, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000003, 32'h00000163, RC};
    vecs[4]  = '{3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0};
    vecs[5]  = '{3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h80000093, RC};
    vecs[6]  = '{3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000093, 1'b0};
    vecs[7]  = '{3'd2, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd1, 7'd0, 32'h00000020, 32'h00001093, RC};
    vecs[8]  = '{3'd2, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd5, 7'b0100000, 32'h0000001F, 32'h41F15093, 1'b0};
    vecs[9]  = '{3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00000000, 32'h002081B3, 1'b0};
    vecs[10] = '{3'd6, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0};
    vecs[11] = '{3'd6, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678, 32'h123452B7, RC};
    vecs[12] = '{3'd4, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000FFE, 32'h7E000FE3, 1'b0};
    vecs[13] = '{3'd3, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFF, 32'hFE21AFA3, 1'b0};
    vecs[14] = '{3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000000, 32'h00000000, 1'b1};
    vecs[15] = '{3'd5, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000001, 32'h0000006F, RC};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(vecs[0]);
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    reset = 1'b0;
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table: one instruction at a time, latency and encoding checked each
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      rdy = in_ready;
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_accept", i), {31'd0, rdy}, 32'd1);
      lat = 1;
      chk($sformatf("v%0d_early_valid", i), {31'd0, out_valid}, 32'd0);
      while (!out_valid && lat < 10) begin
        step();
        lat++;
      end
      chk($sformatf("v%0d_latency", i), lat, 32'd2);
      chk($sformatf("v%0d_word", i), out_word, vecs[i].word);
      chk($sformatf("v%0d_err", i), {31'd0, out_err}, {31'd0, vecs[i].err});
    end
    step();

    // Backpressure: three offered with output stalled, only two fit
    out_ready = 1'b0;
    idx = 0; acc = 0;
    for (int c = 0; c < 4; c++) begin
      drive(vecs[idx]);
      in_valid = 1'b1;
      rdy = in_ready;
      step();
      if (rdy) begin idx++; acc++; end
    end
    drive(vecs[idx]);
    chk("bp_accepted", acc, 32'd2);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    held = out_word;
    chk("bp_head_word", held, vecs[0].word);
    step(); step();
    chk("bp_word_stable", out_word, held);
    out_ready = 1'b1;
    nout = 0;
    for (int c = 0; c < 10; c++) begin
      oc = out_valid && out_ready;
      ic = in_valid && in_ready;
      if (oc && nout < 3) begin rec[nout] = out_word; nout++; end
      step();
      if (ic) begin
        idx++;
        if (idx == 3) in_valid = 1'b0;
        else drive(vecs[idx]);
      end
    end
    chk("bp_out_count", nout, 32'd3);
    chk("bp_third_accepted", idx, 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_order%0d", k), rec[k], vecs[k].word);

    // Reset with two entries in flight
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(vecs[3 + c]);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_pre_in_ready", {31'd0, in_ready}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_async_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_async_word", out_word, 32'd0);
    chk("mid_async_err", {31'd0, out_err}, 32'd0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) stale++;
      step();
    end
    chk("mid_no_stale", stale, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
